// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered interrupt controller with a single non-nesting
// service level. Each source has a pending bit, and ENABLE masks those bits
// for arbitration. The lowest enabled pending index wins and gets one
// redirect pulse (irq). The controller then stays in service until the core
// signals mret_i.
//
// Optional build macro:
//   IRQ_CTRL_SYNC_EN  - each src_i bit passes through a 2-flop synchronizer
//                       before edge detection. This adds 2 cycles of latency.
//                       When undefined, src_i must be synchronous to clk.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   src_i       [NUM_SRC] interrupt request lines (rising-edge triggered)
//   mret_i      one-cycle pulse on return from handler
//   cfg_we      register write strobe
//   cfg_addr    [2]  0 ENABLE (rw), 1 PENDING (w1c), 2 STATUS (ro)
//   cfg_wdata   [32] write data
//   cfg_rdata   [32] combinational read data for cfg_addr
//   irq         one-cycle redirect pulse
//   irq_id      [ID_W] index of the source being serviced
//   in_service  high while a handler is active
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an enabled pending request
// FIRE    | single cycle with irq=1; the winning id is already latched
// SERVICE | handler running; new requests only accumulate; leave on mret_i

module irq_ctrl #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               mret_i,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic [31:0]        cfg_rdata,
   output logic               irq,
   output logic [ID_W-1:0]    irq_id,
   output logic               in_service
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FIRE    = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_fire;

   logic [NUM_SRC-1:0] w_src;
   logic [NUM_SRC-1:0] r_src_prev;
   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic [NUM_SRC-1:0] w_req;
   logic [NUM_SRC-1:0] w_req_low;
   logic [NUM_SRC-1:0] w_fire_clr;
   logic [NUM_SRC-1:0] w_w1c;
   logic               w_any_req;
   logic [ID_W-1:0]    r_irq_id;
   logic [ID_W-1:0]    w_low_id;
   logic               w_unused_wdata;

   // Bits of write data above NUM_SRC have no storage behind them.
   assign w_unused_wdata = ^cfg_wdata;

`ifdef IRQ_CTRL_SYNC_EN
   logic [NUM_SRC-1:0] r_sync1;
   logic [NUM_SRC-1:0] r_sync2;

   always_ff @(posedge clk) begin
      r_sync1 <= src_i;
      r_sync2 <= r_sync1;
   end

   assign w_src = r_sync2;
`else
   assign w_src = src_i;
`endif

   // The edge-detect history has no reset. It follows the line on every clock,
   // including while rst_n is low. As a result, a level that was already high
   // across reset release does not register as a new edge.
   always_ff @(posedge clk) begin
      r_src_prev <= w_src;
   end

   assign w_edge    = w_src & ~r_src_prev;
   assign w_req     = r_pending & r_enable;
   assign w_any_req = |w_req;

   // Isolate the lowest set request bit (x & -x).
   assign w_req_low = w_req & (~w_req + 1'b1);

   always_comb begin
      w_low_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_req[i]) w_low_id = ID_W'(i);
      end
   end

   assign w_fire_clr = w_fire ? w_req_low : '0;
   assign w_w1c      = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_SRC-1:0] : '0;

   // A new edge wins over both the software clear and the arbitration clear.
   assign w_pending_nxt = (r_pending & ~w_w1c & ~w_fire_clr) | w_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_enable  <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (cfg_we && cfg_addr == 2'd0) r_enable <= cfg_wdata[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_irq_id <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_fire) r_irq_id <= w_low_id;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = S_FIRE;
               w_fire      = 1'b1;
            end
         end
         S_FIRE:    w_state_nxt = S_SERVICE;
         S_SERVICE: if (mret_i) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   assign irq        = (r_state == S_FIRE);
   assign in_service = (r_state == S_SERVICE);
   assign irq_id     = r_irq_id;

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         2'd0: cfg_rdata[NUM_SRC-1:0] = r_enable;
         2'd1: cfg_rdata[NUM_SRC-1:0] = r_pending;
         2'd2: begin
            cfg_rdata[8]      = in_service;
            cfg_rdata[ID_W-1:0] = r_irq_id;
         end
         default: cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl in its default build (no source synchronizer).
// Inputs are applied 1 time unit after a rising edge. Outputs are then
// compared before the next edge against hand-computed values from the table.
module tb_irq_ctrl;

   logic        clk;
   logic        rst_n;
   logic [7:0]  src_i;
   logic        mret_i;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        irq;
   logic [4:0]  irq_id;
   logic        in_service;

   int total;
   int bad;

   irq_ctrl #(.NUM_SRC(8), .ID_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_i      (src_i),
      .mret_i     (mret_i),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .irq        (irq),
      .irq_id     (irq_id),
      .in_service (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  src;
      logic        mret;
      logic        e_irq;
      logic [4:0]  e_id;
      logic        e_svc;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                      input logic [7:0] src, input logic mret, input logic e_irq,
                      input logic [4:0] e_id, input logic e_svc, input logic [31:0] e_rd);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.src = src; v.mret = mret;
      v.e_irq = e_irq; v.e_id = e_id; v.e_svc = e_svc; v.e_rd = e_rd;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0; src_i = '0; mret_i = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_inputs();

      // Single source, then an ENABLE clear while in service.
      add(1,0,32'h01,8'h00,0, 0,0,0, 32'h0);
      add(0,0,32'h00,8'h01,0, 0,0,0, 32'h1);
      add(0,1,32'h00,8'h00,0, 0,0,0, 32'h1);
      add(0,1,32'h00,8'h00,0, 1,0,0, 32'h0);
      add(1,0,32'h00,8'h00,0, 0,0,1, 32'h1);
      add(0,2,32'h00,8'h00,1, 0,0,1, 32'h100);
      add(0,2,32'h00,8'h00,0, 0,0,0, 32'h0);
      // Two simultaneous sources: lowest index first, one IDLE cycle in between.
      add(1,0,32'hFF,8'h00,0, 0,0,0, 32'h0);
      add(0,0,32'h00,8'h24,0, 0,0,0, 32'hFF);
      add(0,1,32'h00,8'h00,0, 0,0,0, 32'h24);
      add(0,1,32'h00,8'h00,0, 1,2,0, 32'h20);
      add(0,2,32'h00,8'h00,0, 0,2,1, 32'h102);
      add(0,1,32'h00,8'h00,1, 0,2,1, 32'h20);
      add(0,2,32'h00,8'h00,0, 0,2,0, 32'h002);
      add(0,1,32'h00,8'h00,0, 1,5,0, 32'h0);
      add(0,2,32'h00,8'h00,1, 0,5,1, 32'h105);
      add(0,1,32'h00,8'h00,0, 0,5,0, 32'h0);
      // Masked source latches pending, then fires once enabled.
      add(1,0,32'h00,8'h00,0, 0,5,0, 32'hFF);
      add(0,0,32'h00,8'h08,0, 0,5,0, 32'h0);
      add(0,1,32'h00,8'h00,0, 0,5,0, 32'h08);
      add(1,0,32'h08,8'h00,0, 0,5,0, 32'h0);
      add(0,0,32'h00,8'h00,0, 0,5,0, 32'h08);
      add(0,1,32'h00,8'h00,0, 1,3,0, 32'h0);
      add(0,2,32'h00,8'h00,1, 0,3,1, 32'h103);
      add(0,2,32'h00,8'h00,0, 0,3,0, 32'h003);
      // No nesting: a request raised during service waits for mret.
      add(1,0,32'hFF,8'h01,0, 0,3,0, 32'h08);
      add(0,1,32'h00,8'h00,0, 0,3,0, 32'h01);
      add(0,1,32'h00,8'h00,0, 1,0,0, 32'h0);
      add(0,1,32'h00,8'h02,0, 0,0,1, 32'h0);
      add(0,1,32'h00,8'h00,0, 0,0,1, 32'h02);
      add(0,1,32'h00,8'h00,0, 0,0,1, 32'h02);
      add(0,1,32'h00,8'h00,1, 0,0,1, 32'h02);
      add(0,1,32'h00,8'h00,0, 0,0,0, 32'h02);
      add(0,1,32'h00,8'h00,0, 1,1,0, 32'h0);
      add(0,2,32'h00,8'h00,1, 0,1,1, 32'h101);
      add(0,2,32'h00,8'h00,0, 0,1,0, 32'h001);
      // W1C: an edge in the same cycle wins; a clear on its own takes effect.
      add(1,0,32'h00,8'h00,0, 0,1,0, 32'hFF);
      add(0,1,32'h00,8'h10,0, 0,1,0, 32'h0);
      add(0,1,32'h00,8'h00,0, 0,1,0, 32'h10);
      add(1,1,32'h10,8'h10,0, 0,1,0, 32'h10);
      add(0,1,32'h00,8'h00,0, 0,1,0, 32'h10);
      add(1,1,32'h10,8'h00,0, 0,1,0, 32'h10);
      add(0,1,32'h00,8'h00,0, 0,1,0, 32'h0);
      // STATUS writes are ignored.
      add(1,2,32'hFFFF_FFFF,8'h00,0, 0,1,0, 32'h001);
      add(0,2,32'h00,8'h00,0, 0,1,0, 32'h001);

      repeat (3) tick();
      // Reset state.
      cfg_addr = 2'd0; #1; check("rst_enable", cfg_rdata, 32'h0);
      cfg_addr = 2'd1; #1; check("rst_pending", cfg_rdata, 32'h0);
      cfg_addr = 2'd2; #1; check("rst_status", cfg_rdata, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'h0);
      check("rst_svc", {31'd0, in_service}, 32'h0);
      check("rst_id", {27'd0, irq_id}, 32'h0);
      rst_n = 1'b1;
      idle_inputs();
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         cfg_we    = vecs[i].we;
         cfg_addr  = vecs[i].addr;
         cfg_wdata = vecs[i].wdata;
         src_i     = vecs[i].src;
         mret_i    = vecs[i].mret;
         #1;
         check($sformatf("v%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].e_irq});
         check($sformatf("v%0d_id", i), {27'd0, irq_id}, {27'd0, vecs[i].e_id});
         check($sformatf("v%0d_svc", i), {31'd0, in_service}, {31'd0, vecs[i].e_svc});
         check($sformatf("v%0d_rdata", i), cfg_rdata, vecs[i].e_rd);
         tick();
      end
      idle_inputs();
      tick();

      // Reset in the middle of service, with two requests pending.
      begin
         bit got_svc;
         got_svc = 1'b0;
         cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'hFF; src_i = 8'h01;
         tick();
         idle_inputs();
         for (int k = 0; k < 10 && !got_svc; k++) begin
            tick();
            if (in_service) got_svc = 1'b1;
         end
         check("rstsvc_reach_service", {31'd0, got_svc}, 32'h1);
         src_i = 8'h06;
         tick();
         src_i = 8'h00; cfg_addr = 2'd1; #1;
         check("rstsvc_pending_before", cfg_rdata, 32'h06);
         check("rstsvc_svc_before", {31'd0, in_service}, 32'h1);
         #2;
         rst_n = 1'b0;
         #1;
         check("rstsvc_svc", {31'd0, in_service}, 32'h0);
         check("rstsvc_irq", {31'd0, irq}, 32'h0);
         check("rstsvc_pending", cfg_rdata, 32'h0);
         tick();
         rst_n = 1'b1;
         cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'hFF;
         tick();
         cfg_we = 1'b0;
         begin
            bit saw_irq;
            saw_irq = 1'b0;
            for (int k = 0; k < 10; k++) begin
               if (irq || in_service) saw_irq = 1'b1;
               tick();
            end
            check("rstsvc_no_irq_after", {31'd0, saw_irq}, 32'h0);
         end
         cfg_addr = 2'd1; #1;
         check("rstsvc_pending_after", cfg_rdata, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
